// File: rtl/reward_ctrl.sv
// reward_ctrl: qualifies packets, sequences reward, arbitrates neighbor table, gates TX to own slot.
// Optional slot gating is built when REWARD_CTRL_SLOT_EN is defined.
module reward_ctrl #(
    parameter int             WORD_WIDTH = 16,
    parameter logic [7:0]     TRIG_MASK  = 8'b0000_1110,
    parameter int             TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  pkt_valid,
    input  logic [2:0]            fPacketType,
    input  logic                  iAmDestination,
    input  logic                  low_E,
    output logic                  reward_en,
    input  logic [WORD_WIDTH-1:0] reward_done,
    input  logic [5:0]            nTableIndex_reward,
    input  logic                  qt_req,
    input  logic [5:0]            qt_index,
    output logic                  qt_gnt,
    output logic [5:0]            nt_index,
    input  logic                  slot_tick,
    input  logic [WORD_WIDTH-1:0] frameLen,
    input  logic [WORD_WIDTH-1:0] timeslot,
    output logic [WORD_WIDTH-1:0] slot_cnt,
    output logic                  tx_req,
    input  logic                  tx_ack,
    output logic                  busy,
    output logic                  err_timeout,
    output logic [7:0]            drop_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, START, COMPUTE, WAIT_SLOT, TX} state_t;

`ifdef REWARD_CTRL_SLOT_EN
    localparam state_t DONE_ST = WAIT_SLOT;
`else
    localparam state_t DONE_ST = TX;
`endif

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            pending_q, pending_d;
    logic            err_q, err_d;
    logic            qt_gnt_q, qt_gnt_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic            trig, consume, drop, slot_hit;

    assign trig = pkt_valid & TRIG_MASK[fPacketType] & iAmDestination & ~low_E;

`ifdef REWARD_CTRL_SLOT_EN
    logic [WORD_WIDTH-1:0] slot_cnt_q, slot_cnt_d, last_slot, eff_slot;
    // Slot counter wraps at frameLen-1; a zero frame length pins it at 0
    always_comb begin
        last_slot  = (frameLen == '0) ? '0 : frameLen - WORD_WIDTH'(1);
        eff_slot   = (timeslot < frameLen) ? timeslot : '0;
        slot_cnt_d = !slot_tick ? slot_cnt_q :
                     (slot_cnt_q >= last_slot) ? '0 : slot_cnt_q + WORD_WIDTH'(1);
    end
    // Slot counter register
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) slot_cnt_q <= '0;
        else       slot_cnt_q <= slot_cnt_d;
    assign slot_cnt = slot_cnt_q;
    assign slot_hit = slot_cnt_q == eff_slot;
`else
    logic slot_unused;
    assign slot_unused = ^{slot_tick, frameLen, timeslot};
    assign slot_cnt    = '0;
    assign slot_hit    = 1'b1;
`endif

    // Next-state, timeout tracking, pending/drop bookkeeping and grant logic
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
        consume   = 1'b0;
        case (state_q)
            IDLE: if (trig || pending_q) begin
                state_d = START;
                consume = pending_q;
            end
            START: if (!qt_gnt_q) begin
                state_d   = COMPUTE;
                tmo_cnt_d = '0;
            end
            COMPUTE: if (reward_done != '0) state_d = DONE_ST;
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else tmo_cnt_d = tmo_cnt_q + TW'(1);
            WAIT_SLOT: if (slot_hit) state_d = TX;
            TX: if (tx_ack) begin
                state_d = pending_q ? START : IDLE;
                consume = pending_q;
            end
            default: state_d = IDLE;
        endcase
        pending_d  = (trig && (state_q != IDLE || consume)) ? 1'b1 : consume ? 1'b0 : pending_q;
        drop       = trig & pending_q & ~consume;
        drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
        qt_gnt_d   = qt_req & (qt_gnt_q | (state_d != COMPUTE && state_q != COMPUTE));
    end

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state_q    <= IDLE;
            tmo_cnt_q  <= '0;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
            qt_gnt_q   <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tmo_cnt_q  <= tmo_cnt_d;
            pending_q  <= pending_d;
            err_q      <= err_d;
            qt_gnt_q   <= qt_gnt_d;
            drop_cnt_q <= drop_cnt_d;
        end

    assign reward_en   = (state_q == START) & ~qt_gnt_q;
    assign tx_req      = state_q == TX;
    assign busy        = state_q != IDLE;
    assign qt_gnt      = qt_gnt_q;
    assign nt_index    = (state_q == COMPUTE) ? nTableIndex_reward : qt_index;
    assign err_timeout = err_q;
    assign drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_reward_ctrl.sv
// tb_reward_ctrl: directed self-checking bench for reward_ctrl (slot tests need REWARD_CTRL_SLOT_EN).
module tb_reward_ctrl;
    logic        clk = 1'b0;
    logic        nrst;
    logic        pkt_valid, iAmDestination, low_E;
    logic [2:0]  fPacketType;
    logic        reward_en;
    logic [15:0] reward_done;
    logic [5:0]  nTableIndex_reward, qt_index, nt_index;
    logic        qt_req, qt_gnt;
    logic        slot_tick;
    logic [15:0] frameLen, timeslot, slot_cnt;
    logic        tx_req, tx_ack, busy, err_timeout;
    logic [7:0]  drop_cnt;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    reward_ctrl dut (
        .clk(clk), .nrst(nrst), .pkt_valid(pkt_valid), .fPacketType(fPacketType),
        .iAmDestination(iAmDestination), .low_E(low_E), .reward_en(reward_en),
        .reward_done(reward_done), .nTableIndex_reward(nTableIndex_reward),
        .qt_req(qt_req), .qt_index(qt_index), .qt_gnt(qt_gnt), .nt_index(nt_index),
        .slot_tick(slot_tick), .frameLen(frameLen), .timeslot(timeslot),
        .slot_cnt(slot_cnt), .tx_req(tx_req), .tx_ack(tx_ack), .busy(busy),
        .err_timeout(err_timeout), .drop_cnt(drop_cnt)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pkt(input logic [2:0] t, input logic d, input logic le);
        pkt_valid = 1'b1; fPacketType = t; iAmDestination = d; low_E = le;
        step(1);
        pkt_valid = 1'b0; low_E = 1'b0;
    endtask

    task automatic done_to_tx();
        reward_done = 16'd1;
        step(1);
        reward_done = 16'd0;
`ifdef REWARD_CTRL_SLOT_EN
        step(1);
`endif
    endtask

    task automatic ack();
        tx_ack = 1'b1;
        step(1);
        tx_ack = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; pkt_valid = 1'b0; fPacketType = '0; iAmDestination = 1'b0; low_E = 1'b0;
        reward_done = '0; nTableIndex_reward = 6'd5; qt_req = 1'b0; qt_index = '0;
        slot_tick = 1'b0; frameLen = 16'd4; timeslot = 16'd2; tx_ack = 1'b0;
        step(2);
        chk("rst_busy", busy, 0);
        chk("rst_en", reward_en, 0);
        chk("rst_tx", tx_req, 0);
        chk("rst_gnt", qt_gnt, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_slot", slot_cnt, 0);
        chk("rst_nt", nt_index, 0);
        nrst = 1'b1;
        step(1);

        // single trigger
        pkt(3'd1, 1'b1, 1'b0);
        chk("t1_en", reward_en, 1);
        chk("t1_busy", busy, 1);
        step(1);
        chk("t1_en_width", reward_en, 0);
        qt_index = 6'd9;
        chk("t1_nt_compute", nt_index, 5);
        reward_done = 16'd1;
        step(1);
        reward_done = 16'd0;
`ifdef REWARD_CTRL_SLOT_EN
        chk("t1_wait0", tx_req, 0);
        slot_tick = 1'b1; step(1); slot_tick = 1'b0;
        chk("t1_slot1", slot_cnt, 1);
        chk("t1_wait1", tx_req, 0);
        slot_tick = 1'b1; step(1); slot_tick = 1'b0;
        chk("t1_slot2", slot_cnt, 2);
        chk("t1_wait2", tx_req, 0);
        step(1);
`endif
        chk("t1_tx", tx_req, 1);
        step(2);
        chk("t1_tx_hold", tx_req, 1);
        ack();
        chk("t1_tx_off", tx_req, 0);
        chk("t1_idle", busy, 0);
        qt_index = 6'd0;

        // filtered packets
        pkt(3'd0, 1'b1, 1'b0);
        chk("f_type0", busy, 0);
        pkt(3'd1, 1'b0, 1'b0);
        chk("f_dest0", busy, 0);
        pkt(3'd2, 1'b1, 1'b1);
        chk("f_lowE", busy, 0);
        chk("f_en", reward_en, 0);

        // overflow: three consecutive triggers
        pkt_valid = 1'b1; fPacketType = 3'd3; iAmDestination = 1'b1;
        step(1);
        chk("ov_en1", reward_en, 1);
        step(2);
        pkt_valid = 1'b0;
        chk("ov_drop", drop_cnt, 1);
        done_to_tx();
        chk("ov_tx1", tx_req, 1);
        ack();
        chk("ov_en2", reward_en, 1);
        step(1);
        done_to_tx();
        chk("ov_tx2", tx_req, 1);
        ack();
        chk("ov_idle", busy, 0);
        chk("ov_drop_keep", drop_cnt, 1);

        // timeout
        pkt(3'd1, 1'b1, 1'b0);
        step(1);
        step(63);
        chk("to_busy63", busy, 1);
        chk("to_err63", err_timeout, 0);
        step(1);
        chk("to_idle", busy, 0);
        chk("to_err", err_timeout, 1);
        chk("to_tx", tx_req, 0);

        // arbiter
        qt_req = 1'b1; qt_index = 6'd7; nTableIndex_reward = 6'd12;
        step(1);
        chk("arb_gnt", qt_gnt, 1);
        chk("arb_nt_qt", nt_index, 7);
        pkt(3'd2, 1'b1, 1'b0);
        chk("arb_stall_en", reward_en, 0);
        chk("arb_stall_busy", busy, 1);
        step(1);
        chk("arb_stall_en2", reward_en, 0);
        qt_req = 1'b0;
        step(1);
        chk("arb_gnt_off", qt_gnt, 0);
        chk("arb_en", reward_en, 1);
        step(1);
        chk("arb_nt_rw", nt_index, 12);
        qt_req = 1'b1;
        step(1);
        chk("arb_no_gnt", qt_gnt, 0);
        chk("arb_nt_rw2", nt_index, 12);
        qt_req = 1'b0; qt_index = 6'd0;
        done_to_tx();
        chk("arb_tx", tx_req, 1);

        // asynchronous reset mid-TX
        #2 nrst = 1'b0;
        #1;
        chk("rx_tx", tx_req, 0);
        chk("rx_busy", busy, 0);
        chk("rx_err", err_timeout, 0);
        chk("rx_drop", drop_cnt, 0);
        chk("rx_nt", nt_index, 0);
        step(1);
        nrst = 1'b1;
        step(1);

`ifdef REWARD_CTRL_SLOT_EN
        timeslot = 16'd7;
        pkt(3'd1, 1'b1, 1'b0);
        step(1);
        done_to_tx();
        chk("ts7_tx", tx_req, 1);
        ack();
        slot_tick = 1'b1; step(4); slot_tick = 1'b0;
        chk("slot_wrap", slot_cnt, 0);
        frameLen = 16'd0;
        slot_tick = 1'b1; step(2); slot_tick = 1'b0;
        chk("slot_flen0", slot_cnt, 0);
`else
        slot_tick = 1'b1; step(3); slot_tick = 1'b0;
        chk("slot_tied", slot_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reward_ctrl.md
# reward_ctrl

Sequencer and neighbor-table arbiter for the `reward` block. It qualifies incoming packets from `packetFilter` and pulses `reward.en` once per qualifying packet. It shares the neighbor-table read port between `reward` and QTUFMB, and holds each computed reward packet until the node's own TDMA timeslot. It then hands the packet to the transmitter with a req/ack handshake.

## Interface
- `WORD_WIDTH`, 16: data/ID/timeslot width.
- `TRIG_MASK`, 8'b0000_1110: bit *k* set means packet type *k* triggers a reward.
- `TIMEOUT`, 64: maximum cycles spent in COMPUTE.

- `clk` in 1: clock.
- `nrst` in 1: asynchronous, active-low reset.
- `pkt_valid` in 1: one-cycle pulse, a packet has been accepted by `packetFilter`.
- `fPacketType` in 3: type of that packet.
- `iAmDestination` in 1: this node is the packet's destination.
- `low_E` in 1: node is in low-energy mode.
- `reward_en` out 1: drives `reward.en`.
- `reward_done` in WORD_WIDTH: from `reward`; any nonzero value means done.
- `nTableIndex_reward` in 6: neighbor-table index requested by `reward`.
- `qt_req` in 1: QTUFMB requests the neighbor table.
- `qt_index` in 6: QTUFMB neighbor-table index.
- `qt_gnt` out 1: QTUFMB owns the neighbor table.
- `nt_index` out 6: muxed neighbor-table address.
- `slot_tick` in 1: one-cycle pulse at each timeslot boundary.
- `frameLen` in WORD_WIDTH: slots per frame.
- `timeslot` in WORD_WIDTH: this node's own slot.
- `slot_cnt` out WORD_WIDTH: current slot number.
- `tx_req` out 1: reward packet (`r*` outputs of `reward`) is ready to send.
- `tx_ack` in 1: transmitter has taken the packet.
- `busy` out 1: state is not IDLE.
- `err_timeout` out 1: sticky, set when COMPUTE times out.
- `drop_cnt` out 8: saturating count of dropped triggers.

## Operation
- **Trigger condition:** `trig = pkt_valid & TRIG_MASK[fPacketType] & iAmDestination & ~low_E`.
- **States:** IDLE, START, COMPUTE, WAIT_SLOT, TX.
- **IDLE:** on `trig`, go to START.
- **START:**
  - `reward_en = ~qt_gnt`.
  - When `~qt_gnt`, go to COMPUTE and clear `tmo_cnt`.
  - While `qt_gnt` is high, stay in START; no timeout applies here.
- **COMPUTE:**
  - `nt_index = nTableIndex_reward`.
  - If `reward_done != 0`, go to WAIT_SLOT.
  - Otherwise, if `tmo_cnt == TIMEOUT-1`, set `err_timeout` and go to IDLE (the pending request is kept and served next).
  - Otherwise, increment `tmo_cnt`.
  - If done and timeout occur in the same cycle, done wins.
- **WAIT_SLOT:** go to TX when `slot_cnt == eff_slot`.
  - `eff_slot = timeslot` if `timeslot < frameLen`, else 0.
- **TX:**
  - `tx_req = 1`.
  - On `tx_ack`: go to START if `pending`, clearing `pending` in the same cycle; otherwise go to IDLE.
- **Pending request:**
  - A `trig` seen in any state other than IDLE sets the 1-deep `pending` flag.
  - A `trig` while `pending` is already set increments `drop_cnt` (saturates at 255).
  - When `pending` is consumed in the same cycle a new `trig` arrives, `pending` stays 1 and nothing is dropped.
  - IDLE with `pending` set goes to START unconditionally.
- **Neighbor-table arbiter:**
  - `qt_gnt` is registered: it sets on `qt_req` when the next state is not COMPUTE and the current state is not COMPUTE.
  - It holds until `qt_req` is low; it then clears on the next edge.
  - `nt_index = qt_index` whenever the state is not COMPUTE.
- **Slot counter:**
  - On `slot_tick`, if `slot_cnt >= frameLen-1`, `slot_cnt` goes to 0; otherwise it increments.
  - `frameLen == 0` is treated as 1, so `slot_cnt` stays 0.

## Timing
- **Reset values:** every output and register is 0: state IDLE, `reward_en`, `qt_gnt`, `tx_req`, `busy`, `err_timeout`, `pending`, `drop_cnt`, `slot_cnt`, `tmo_cnt`, `nt_index`.
- `err_timeout` clears only on reset.
- `tx_req`, `reward_en`, and `busy` are decoded from the registered state. `reward_en` additionally depends on the registered `qt_gnt`.
- **Minimum latency:**
  - `pkt_valid` sampled at edge N gives `reward_en` during cycle N+1.
  - `reward_done` sampled at edge M gives `tx_req` during cycle M+2 when the slot already matches.
  - `tx_ack` sampled at edge T drops `tx_req` in cycle T+1.
- `reward_en` is exactly one cycle wide.
- `tx_req` stays high until `tx_ack` is sampled.
- **Reset mid-operation:** an asynchronous `nrst` low returns everything to reset values immediately. Any in-flight reward is discarded.

## Configuration
- **`REWARD_CTRL_SLOT_EN` defined:** WAIT_SLOT and the slot counter are built as described above.
- **`REWARD_CTRL_SLOT_EN` undefined:**
  - COMPUTE goes directly to TX on done.
  - `slot_cnt` is tied to 0.
  - `slot_tick`, `frameLen`, and `timeslot` are ignored.

## Test plan
- **Single trigger:** reset, `frameLen=4`, `timeslot=2`, `slot_cnt=0`; `pkt_valid` with type 1, dest=1 → `reward_en` for 1 cycle. Then `reward_done=1` → `tx_req` only after two `slot_tick`s (`slot_cnt=2`). Then `tx_ack` → IDLE, `busy=0`.
- **Filtered packets:** type 0 packet, or dest=0, or `low_E=1` → no `reward_en`, `busy` stays 0.
- **Overflow:** three triggers in a row during COMPUTE → `pending=1`, `drop_cnt=1`. After the first `tx_ack`, START is entered directly and a second `reward_en` pulse occurs.
- **Timeout:** `reward_done` held at 0 → exit to IDLE 64 cycles after entering COMPUTE, `err_timeout=1`, no `tx_req`.
- **Arbiter:** `qt_req` high before a trigger → `qt_gnt=1`, `nt_index=qt_index`, START stalls with `reward_en=0`. Drop `qt_req` → `qt_gnt=0`, `reward_en` pulses, and during COMPUTE `nt_index` follows `nTableIndex_reward` while `qt_gnt` stays 0.
- **Reset mid-TX:** `nrst` low while `tx_req=1` → all outputs 0 at once. Also, `timeslot=7` with `frameLen=4` → transmit at slot 0.
